id_pipe: RTL and testbench
==========================

Name: id_pipe

Overview:
- Registered, parametrised RV32I decode stage between if_id and id_ex.
- Decodes I/R/B/L/S/JAL/JALR/AUIPC/LUI. Forwards operands from the EX and MEM stages and stalls on load-use hazards.
- Captures results in an output register with a valid/ready handshake, so the pipeline can back-pressure.
- Supports a flush for taken branches and jumps.

Parameters:
- XLEN, 32, datapath width (32 or 64). Instructions stay 32 bits. Immediates and PC are sign/zero-extended to XLEN.
- LOAD_USE_STALL, 1, 1 = insert a bubble on a load-use hazard; 0 = never stall (the software guarantees no hazard).

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- in_valid_i  in  1  if_id holds an instruction
- in_ready_o  out  1  id_pipe accepts the instruction this cycle
- inst_i  in  32  instruction
- inst_addr_i  in  XLEN  instruction PC
- rs1_addr_o / rs2_addr_o  out  5  regfile read addresses (combinational)
- rs1_data_i / rs2_data_i  in  XLEN  regfile read data
- ex_wen_i, ex_rd_i[5], ex_data_i[XLEN], ex_is_load_i  in  EX-stage writeback candidate
- mem_wen_i, mem_rd_i[5], mem_data_i[XLEN]  in  MEM-stage writeback candidate
- flush_i  in  1  kill the registered and incoming instruction
- out_valid_o  out  1  output register holds a valid instruction
- out_ready_i  in  1  id_ex accepts
- inst_o[32], inst_addr_o[XLEN], op1_o[XLEN], op2_o[XLEN], rd_addr_o[5], reg_wen_o, base_addr_o[XLEN], addr_offset_o[XLEN], mem_rd_req_o, mem_rd_addr_o[XLEN], illegal_o  out  registered decode results

Behaviour:
- Reset: every registered output and out_valid_o is 0. Asynchronous assertion; deassertion is synchronous to clk.
- Operand source, per rs, in priority order:
  - rs == 0 -> 0
  - ex_wen_i && ex_rd_i == rs && !ex_is_load_i -> ex_data_i
  - mem_wen_i && mem_rd_i == rs -> mem_data_i
  - otherwise regfile data
- Source usage:
  - rs1 used by I, R, B, L, S, JALR.
  - rs2 used by R, B, S.
  - rs*_addr_o = 0 when the source is unused.
- stall = LOAD_USE_STALL && in_valid_i && ex_wen_i && ex_is_load_i && ex_rd_i != 0 && (a used rs matches ex_rd_i).
- in_ready_o = (!out_valid_o || out_ready_i) && !stall && !flush_i.
- Capture: when in_valid_i && in_ready_o, the decode results are registered next edge and out_valid_o <= 1.
- Drain: when out_valid_o && out_ready_i && no capture, out_valid_o <= 0. On a stall this produces exactly one bubble per stall cycle.
- Hold: when out_valid_o && !out_ready_i, all outputs hold stable.
- Flush has priority over everything: out_valid_o <= 0 next edge and nothing is captured. The incoming instruction is not consumed; if_id discards it.
- Decode results, with imm sign-extended to XLEN:
  - OP-IMM: op1 = rs1, op2 = imm. Shifts: op2 = shamt (5 bits at XLEN=32, 6 bits at XLEN=64).
  - OP: op1 = rs1, op2 = rs2. For SLL/SRL/SRA, op2 = rs2 masked to the shift width.
  - BRANCH: op1 = rs1, op2 = rs2, base = pc, offset = B-imm, reg_wen = 0.
  - LOAD: mem_rd_req = 1, base = rs1, offset = I-imm, mem_rd_addr = rs1 + I-imm (modulo 2^XLEN), op1 = op2 = 0.
  - STORE: op2 = rs2, base = rs1, offset = S-imm, reg_wen = 0.
  - JAL: op1 = pc, op2 = 4, base = pc, offset = J-imm.
  - JALR: op1 = pc, op2 = 4, base = rs1, offset = I-imm.
  - AUIPC: op1 = U-imm, op2 = pc.
  - LUI: op1 = U-imm, op2 = 0.
- Invalid opcode or func3: illegal_o = 1 and all control/data outputs = 0. out_valid_o still asserts so downstream can trap.
- rd_addr_o = rd and reg_wen_o = 1 for writing instructions, except reg_wen_o = 0 when rd = 0.

Optional Feature:
- Macro: ID_PIPE_STALL_CNT_EN.
- Defined: adds output stall_cnt_o[32], reset to 0. It increments on each cycle where stall = 1, saturating at 0xFFFFFFFF and clearing only on rst.
- Undefined: the port and the counter are absent, and there is no other change.

Test Plan:
- ADDI x1,x0,5 (0x00500093) with out_ready_i = 1 -> next cycle out_valid_o = 1, op1_o = 0, op2_o = 5, rd_addr_o = 1, reg_wen_o = 1.
- ADD x3,x1,x2 with ex_wen_i = 1, ex_rd_i = 1, ex_data_i = 7, mem_wen_i = 1, mem_rd_i = 1, mem_data_i = 9, rs2 regfile = 3 -> op1_o = 7 (EX wins), op2_o = 3.
- LW x1 in EX (ex_is_load_i = 1, ex_rd_i = 1) and SW x1,0(x2) at input -> in_ready_o = 0 and out_valid_o = 0 for one cycle. Then ex_is_load_i drops, and the store is captured with operands from MEM forwarding.
- out_ready_i = 0 for 3 cycles after a BEQ capture -> outputs stable, in_ready_o = 0. Then out_ready_i = 1 drains the branch and captures the next instruction the same edge.
- flush_i during a held valid output -> out_valid_o = 0 next cycle and in_ready_o = 0 during the flush.
- Opcode 0x7F -> illegal_o = 1, reg_wen_o = 0, out_valid_o = 1. rst asserted mid-hold -> all outputs 0 immediately.

Source files
------------

// File: rtl/id_pipe_if.sv
// rtl/id_pipe_if.sv - decode stage bus: if_id handshake, regfile read, bypass inputs, id_ex output register
interface id_pipe_if #(parameter int XLEN = 32);
  logic            in_valid_i;
  logic            in_ready_o;
  logic [31:0]     inst_i;
  logic [XLEN-1:0] inst_addr_i;
  logic [4:0]      rs1_addr_o;
  logic [4:0]      rs2_addr_o;
  logic [XLEN-1:0] rs1_data_i;
  logic [XLEN-1:0] rs2_data_i;
  logic            ex_wen_i;
  logic [4:0]      ex_rd_i;
  logic [XLEN-1:0] ex_data_i;
  logic            ex_is_load_i;
  logic            mem_wen_i;
  logic [4:0]      mem_rd_i;
  logic [XLEN-1:0] mem_data_i;
  logic            flush_i;
  logic            out_valid_o;
  logic            out_ready_i;
  logic [31:0]     inst_o;
  logic [XLEN-1:0] inst_addr_o;
  logic [XLEN-1:0] op1_o;
  logic [XLEN-1:0] op2_o;
  logic [4:0]      rd_addr_o;
  logic            reg_wen_o;
  logic [XLEN-1:0] base_addr_o;
  logic [XLEN-1:0] addr_offset_o;
  logic            mem_rd_req_o;
  logic [XLEN-1:0] mem_rd_addr_o;
  logic            illegal_o;

  modport slave (
    input  in_valid_i, inst_i, inst_addr_i, rs1_data_i, rs2_data_i,
           ex_wen_i, ex_rd_i, ex_data_i, ex_is_load_i,
           mem_wen_i, mem_rd_i, mem_data_i, flush_i, out_ready_i,
    output in_ready_o, rs1_addr_o, rs2_addr_o, out_valid_o, inst_o, inst_addr_o,
           op1_o, op2_o, rd_addr_o, reg_wen_o, base_addr_o, addr_offset_o,
           mem_rd_req_o, mem_rd_addr_o, illegal_o
  );

  modport master (
    output in_valid_i, inst_i, inst_addr_i, rs1_data_i, rs2_data_i,
           ex_wen_i, ex_rd_i, ex_data_i, ex_is_load_i,
           mem_wen_i, mem_rd_i, mem_data_i, flush_i, out_ready_i,
    input  in_ready_o, rs1_addr_o, rs2_addr_o, out_valid_o, inst_o, inst_addr_o,
           op1_o, op2_o, rd_addr_o, reg_wen_o, base_addr_o, addr_offset_o,
           mem_rd_req_o, mem_rd_addr_o, illegal_o
  );
endinterface

// File: rtl/id_pipe.sv
// rtl/id_pipe.sv - registered RV32I decode stage with bypass, load-use stall and flush; ID_PIPE_STALL_CNT_EN adds stall_cnt_o
module id_pipe #(
  parameter int XLEN           = 32,
  parameter int LOAD_USE_STALL = 1
) (
  input  logic        clk,
  input  logic        rst,
  id_pipe_if.slave    bus
`ifdef ID_PIPE_STALL_CNT_EN
  ,
  output logic [31:0] stall_cnt_o
`endif
);
  localparam int SHW = (XLEN == 64) ? 6 : 5;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  logic [31:0]     inst;
  logic [6:0]      opcode;
  logic [2:0]      funct3;
  logic [4:0]      rd, rs1, rs2;
  logic [XLEN-1:0] pc, i_imm, s_imm, b_imm, j_imm, u_imm, shamt, sh_mask;
  logic [XLEN-1:0] rs1_val, rs2_val;
  logic            legal, use1, use2, writes, is_shift;
  logic            stall, capture;
  logic [XLEN-1:0] d_op1, d_op2, d_base, d_off, d_maddr;
  logic            d_mrd;

  assign inst    = bus.inst_i;
  assign pc      = bus.inst_addr_i;
  assign opcode  = inst[6:0];
  assign rd      = inst[11:7];
  assign funct3  = inst[14:12];
  assign rs1     = inst[19:15];
  assign rs2     = inst[24:20];
  assign i_imm   = XLEN'($signed(inst[31:20]));
  assign s_imm   = XLEN'($signed({inst[31:25], inst[11:7]}));
  assign b_imm   = XLEN'($signed({inst[31], inst[7], inst[30:25], inst[11:8], 1'b0}));
  assign j_imm   = XLEN'($signed({inst[31], inst[19:12], inst[20], inst[30:21], 1'b0}));
  assign u_imm   = XLEN'($signed({inst[31:12], 12'b0}));
  assign shamt   = {{(XLEN-SHW){1'b0}}, inst[20 +: SHW]};
  assign sh_mask = {{(XLEN-SHW){1'b0}}, {SHW{1'b1}}};
  assign is_shift = (funct3 == 3'b001) || (funct3 == 3'b101);

  // EX beats MEM; a load still in EX has no data yet so it never bypasses
  function automatic logic [XLEN-1:0] fwd(
    input logic [4:0] rs, input logic [XLEN-1:0] rf,
    input logic ex_wen, input logic [4:0] ex_rd, input logic ex_ld, input logic [XLEN-1:0] ex_data,
    input logic mem_wen, input logic [4:0] mem_rd, input logic [XLEN-1:0] mem_data);
    if (rs == 5'd0)                              return '0;
    else if (ex_wen && ex_rd == rs && !ex_ld)    return ex_data;
    else if (mem_wen && mem_rd == rs)            return mem_data;
    else                                         return rf;
  endfunction

  assign rs1_val = fwd(rs1, bus.rs1_data_i, bus.ex_wen_i, bus.ex_rd_i, bus.ex_is_load_i, bus.ex_data_i,
                       bus.mem_wen_i, bus.mem_rd_i, bus.mem_data_i);
  assign rs2_val = fwd(rs2, bus.rs2_data_i, bus.ex_wen_i, bus.ex_rd_i, bus.ex_is_load_i, bus.ex_data_i,
                       bus.mem_wen_i, bus.mem_rd_i, bus.mem_data_i);

  // Legality and source usage depend only on opcode/funct3, kept apart from the operand path
  always_comb begin
    legal  = 1'b0;
    use1   = 1'b0;
    use2   = 1'b0;
    writes = 1'b0;
    case (opcode)
      OPC_OPIMM:  begin legal = 1'b1; use1 = 1'b1; writes = 1'b1; end
      OPC_OP:     begin legal = 1'b1; use1 = 1'b1; use2 = 1'b1; writes = 1'b1; end
      OPC_BRANCH: begin
        legal = (funct3 != 3'b010) && (funct3 != 3'b011);
        use1  = legal;
        use2  = legal;
      end
      OPC_LOAD: begin
        legal  = (funct3 == 3'b000) || (funct3 == 3'b001) || (funct3 == 3'b010) ||
                 (funct3 == 3'b100) || (funct3 == 3'b101) ||
                 ((XLEN == 64) && ((funct3 == 3'b011) || (funct3 == 3'b110)));
        use1   = legal;
        writes = legal;
      end
      OPC_STORE: begin
        legal = (funct3 <= 3'b010) || ((XLEN == 64) && (funct3 == 3'b011));
        use1  = legal;
        use2  = legal;
      end
      OPC_JAL:    begin legal = 1'b1; writes = 1'b1; end
      OPC_JALR:   begin legal = (funct3 == 3'b000); use1 = legal; writes = legal; end
      OPC_AUIPC,
      OPC_LUI:    begin legal = 1'b1; writes = 1'b1; end
      default:    ;
    endcase
  end

  assign bus.rs1_addr_o = use1 ? rs1 : 5'd0;
  assign bus.rs2_addr_o = use2 ? rs2 : 5'd0;

  assign stall = (LOAD_USE_STALL != 0) && bus.in_valid_i && bus.ex_wen_i && bus.ex_is_load_i &&
                 (bus.ex_rd_i != 5'd0) &&
                 ((use1 && rs1 == bus.ex_rd_i) || (use2 && rs2 == bus.ex_rd_i));
  assign bus.in_ready_o = (!bus.out_valid_o || bus.out_ready_i) && !stall && !bus.flush_i;
  assign capture        = bus.in_valid_i && bus.in_ready_o;

  // Operand and address selection; illegal encodings leave everything at zero
  always_comb begin
    d_op1   = '0;
    d_op2   = '0;
    d_base  = '0;
    d_off   = '0;
    d_maddr = '0;
    d_mrd   = 1'b0;
    if (legal) begin
      case (opcode)
        OPC_OPIMM:  begin d_op1 = rs1_val; d_op2 = is_shift ? shamt : i_imm; end
        OPC_OP:     begin d_op1 = rs1_val; d_op2 = is_shift ? (rs2_val & sh_mask) : rs2_val; end
        OPC_BRANCH: begin d_op1 = rs1_val; d_op2 = rs2_val; d_base = pc; d_off = b_imm; end
        OPC_LOAD:   begin d_mrd = 1'b1; d_base = rs1_val; d_off = i_imm; d_maddr = rs1_val + i_imm; end
        OPC_STORE:  begin d_op2 = rs2_val; d_base = rs1_val; d_off = s_imm; end
        OPC_JAL:    begin d_op1 = pc; d_op2 = XLEN'(4); d_base = pc; d_off = j_imm; end
        OPC_JALR:   begin d_op1 = pc; d_op2 = XLEN'(4); d_base = rs1_val; d_off = i_imm; end
        OPC_AUIPC:  begin d_op1 = u_imm; d_op2 = pc; end
        OPC_LUI:    begin d_op1 = u_imm; end
        default:    ;
      endcase
    end
  end

  // Output register: flush wins, then capture, then drain; otherwise hold
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.out_valid_o   <= 1'b0;
      bus.inst_o        <= '0;
      bus.inst_addr_o   <= '0;
      bus.op1_o         <= '0;
      bus.op2_o         <= '0;
      bus.rd_addr_o     <= '0;
      bus.reg_wen_o     <= 1'b0;
      bus.base_addr_o   <= '0;
      bus.addr_offset_o <= '0;
      bus.mem_rd_req_o  <= 1'b0;
      bus.mem_rd_addr_o <= '0;
      bus.illegal_o     <= 1'b0;
    end else if (bus.flush_i) begin
      bus.out_valid_o <= 1'b0;
    end else if (capture) begin
      bus.out_valid_o   <= 1'b1;
      bus.inst_o        <= inst;
      bus.inst_addr_o   <= pc;
      bus.op1_o         <= d_op1;
      bus.op2_o         <= d_op2;
      bus.rd_addr_o     <= writes ? rd : 5'd0;
      bus.reg_wen_o     <= writes && (rd != 5'd0);
      bus.base_addr_o   <= d_base;
      bus.addr_offset_o <= d_off;
      bus.mem_rd_req_o  <= d_mrd;
      bus.mem_rd_addr_o <= d_maddr;
      bus.illegal_o     <= !legal;
    end else if (bus.out_ready_i) begin
      bus.out_valid_o <= 1'b0;
    end
  end

`ifdef ID_PIPE_STALL_CNT_EN
  // Saturating count of load-use stall cycles
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      stall_cnt_o <= '0;
    else if (stall && (stall_cnt_o != 32'hFFFF_FFFF))
      stall_cnt_o <= stall_cnt_o + 32'd1;
  end
`endif
endmodule

// File: tb/tb_id_pipe.sv
// tb/tb_id_pipe.sv - directed-vector bench for id_pipe
module tb_id_pipe;
  localparam int XLEN = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  id_pipe_if #(.XLEN(XLEN)) bus();

`ifdef ID_PIPE_STALL_CNT_EN
  logic [31:0] stall_cnt;
`endif

  id_pipe #(.XLEN(XLEN), .LOAD_USE_STALL(1)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
`ifdef ID_PIPE_STALL_CNT_EN
    ,
    .stall_cnt_o (stall_cnt)
`endif
  );

  int n_chk  = 0;
  int n_fail = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic present(input logic [31:0] ins, input logic [31:0] pc,
                         input logic [31:0] r1, input logic [31:0] r2);
    bus.in_valid_i  = 1'b1;
    bus.inst_i      = ins;
    bus.inst_addr_i = pc;
    bus.rs1_data_i  = r1;
    bus.rs2_data_i  = r2;
    #1;
  endtask

  task automatic no_bypass();
    bus.ex_wen_i     = 1'b0;
    bus.ex_rd_i      = 5'd0;
    bus.ex_data_i    = '0;
    bus.ex_is_load_i = 1'b0;
    bus.mem_wen_i    = 1'b0;
    bus.mem_rd_i     = 5'd0;
    bus.mem_data_i   = '0;
  endtask

  initial begin
    bus.in_valid_i  = 1'b0;
    bus.inst_i      = '0;
    bus.inst_addr_i = '0;
    bus.rs1_data_i  = '0;
    bus.rs2_data_i  = '0;
    bus.flush_i     = 1'b0;
    bus.out_ready_i = 1'b1;
    no_bypass();

    repeat (2) cycle();
    check("rst_valid", bus.out_valid_o, 0);
    check("rst_op1", bus.op1_o, 0);
    check("rst_wen", bus.reg_wen_o, 0);
    check("rst_ill", bus.illegal_o, 0);
    rst = 1'b0;

    // ADDI x1,x0,5
    present(32'h00500093, 32'h100, 32'h0, 32'h0);
    check("addi_ready", bus.in_ready_o, 1);
    check("addi_rs1a", bus.rs1_addr_o, 0);
    check("addi_rs2a", bus.rs2_addr_o, 0);
    cycle();
    check("addi_valid", bus.out_valid_o, 1);
    check("addi_op1", bus.op1_o, 0);
    check("addi_op2", bus.op2_o, 5);
    check("addi_rd", bus.rd_addr_o, 1);
    check("addi_wen", bus.reg_wen_o, 1);
    check("addi_pc", bus.inst_addr_o, 32'h100);

    // ADD x3,x1,x2: EX and MEM both target x1, EX wins
    bus.ex_wen_i = 1'b1; bus.ex_rd_i = 5'd1; bus.ex_data_i = 32'd7;
    bus.mem_wen_i = 1'b1; bus.mem_rd_i = 5'd1; bus.mem_data_i = 32'd9;
    present(32'h002081B3, 32'h104, 32'h55, 32'd3);
    check("add_rs1a", bus.rs1_addr_o, 1);
    check("add_rs2a", bus.rs2_addr_o, 2);
    cycle();
    check("add_op1", bus.op1_o, 7);
    check("add_op2", bus.op2_o, 3);
    check("add_rd", bus.rd_addr_o, 3);

    // SLL x5,x6,x7: rs2 from MEM, masked to 5 bits
    no_bypass();
    bus.mem_wen_i = 1'b1; bus.mem_rd_i = 5'd7; bus.mem_data_i = 32'h123;
    present(32'h007312B3, 32'h108, 32'hAAAA0000, 32'h0);
    cycle();
    check("sll_op1", bus.op1_o, 32'hAAAA0000);
    check("sll_op2", bus.op2_o, 3);

    // SW x1,0(x2) behind LW x1 in EX: one bubble
    no_bypass();
    bus.ex_wen_i = 1'b1; bus.ex_rd_i = 5'd1; bus.ex_is_load_i = 1'b1; bus.ex_data_i = 32'hBAD;
    present(32'h00112023, 32'h10C, 32'h1000, 32'hDEAD);
    check("sw_stall_ready", bus.in_ready_o, 0);
    check("sw_rs2a", bus.rs2_addr_o, 1);
    cycle();
    check("sw_bubble", bus.out_valid_o, 0);
    no_bypass();
    bus.mem_wen_i = 1'b1; bus.mem_rd_i = 5'd1; bus.mem_data_i = 32'h77;
    #1;
    check("sw_ready", bus.in_ready_o, 1);
    cycle();
    check("sw_valid", bus.out_valid_o, 1);
    check("sw_op1", bus.op1_o, 0);
    check("sw_op2", bus.op2_o, 32'h77);
    check("sw_base", bus.base_addr_o, 32'h1000);
    check("sw_wen", bus.reg_wen_o, 0);

    // BEQ x1,x2,-4 then back-pressure for 3 cycles
    no_bypass();
    present(32'hFE208EE3, 32'h200, 32'h11, 32'h22);
    cycle();
    check("beq_op1", bus.op1_o, 32'h11);
    check("beq_op2", bus.op2_o, 32'h22);
    check("beq_base", bus.base_addr_o, 32'h200);
    check("beq_off", bus.addr_offset_o, 32'hFFFFFFFC);
    check("beq_wen", bus.reg_wen_o, 0);
    bus.out_ready_i = 1'b0;
    present(32'h12345237, 32'h204, 32'h0, 32'h0);
    for (int i = 0; i < 3; i++) begin
      check("hold_ready", bus.in_ready_o, 0);
      cycle();
      check("hold_valid", bus.out_valid_o, 1);
      check("hold_inst", bus.inst_o, 32'hFE208EE3);
      check("hold_op1", bus.op1_o, 32'h11);
    end
    bus.out_ready_i = 1'b1;
    #1;
    check("lui_ready", bus.in_ready_o, 1);
    cycle();
    check("lui_valid", bus.out_valid_o, 1);
    check("lui_inst", bus.inst_o, 32'h12345237);
    check("lui_op1", bus.op1_o, 32'h12345000);
    check("lui_op2", bus.op2_o, 0);
    check("lui_rd", bus.rd_addr_o, 4);

    // Flush while LUI is held
    bus.out_ready_i = 1'b0;
    present(32'h00001297, 32'h300, 32'h0, 32'h0);
    cycle();
    check("fl_hold", bus.inst_o, 32'h12345237);
    bus.flush_i = 1'b1;
    #1;
    check("fl_ready", bus.in_ready_o, 0);
    cycle();
    check("fl_valid", bus.out_valid_o, 0);
    bus.flush_i = 1'b0;
    bus.out_ready_i = 1'b1;
    cycle();
    check("auipc_valid", bus.out_valid_o, 1);
    check("auipc_op1", bus.op1_o, 32'h1000);
    check("auipc_op2", bus.op2_o, 32'h300);
    check("auipc_rd", bus.rd_addr_o, 5);

    // JAL x1,+16
    present(32'h010000EF, 32'h400, 32'h0, 32'h0);
    cycle();
    check("jal_op1", bus.op1_o, 32'h400);
    check("jal_op2", bus.op2_o, 4);
    check("jal_off", bus.addr_offset_o, 16);

    // LW x6,-8(x2)
    present(32'hFF812303, 32'h404, 32'h1004, 32'h0);
    cycle();
    check("lw_req", bus.mem_rd_req_o, 1);
    check("lw_addr", bus.mem_rd_addr_o, 32'h0FFC);
    check("lw_off", bus.addr_offset_o, 32'hFFFFFFF8);
    check("lw_op1", bus.op1_o, 0);
    check("lw_rd", bus.rd_addr_o, 6);

    // SRAI x7,x8,3
    present(32'h40345393, 32'h408, 32'hF0, 32'h0);
    cycle();
    check("srai_op1", bus.op1_o, 32'hF0);
    check("srai_op2", bus.op2_o, 3);

    // ADDI x0,x0,0 never writes
    present(32'h00000013, 32'h40C, 32'h0, 32'h0);
    cycle();
    check("nop_wen", bus.reg_wen_o, 0);

    // Opcode 0x7F
    present(32'h0000007F, 32'h410, 32'h5, 32'h6);
    cycle();
    check("ill_flag", bus.illegal_o, 1);
    check("ill_valid", bus.out_valid_o, 1);
    check("ill_wen", bus.reg_wen_o, 0);
    check("ill_op1", bus.op1_o, 0);

    // Reset mid-hold clears outputs without a clock edge
    bus.out_ready_i = 1'b0;
    bus.in_valid_i  = 1'b0;
    cycle();
    check("pre_rst_valid", bus.out_valid_o, 1);
    #2 rst = 1'b1;
    #1;
    check("mid_rst_valid", bus.out_valid_o, 0);
    check("mid_rst_ill", bus.illegal_o, 0);
    check("mid_rst_inst", bus.inst_o, 0);
`ifdef ID_PIPE_STALL_CNT_EN
    check("stall_cnt_rst", stall_cnt, 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
